// File: rtl/dat_pkg.sv
// Shared definitions for the SD data path: CRC status tokens and the
// per-block outcome codes consumed by the data-path controller.
package dat_pkg;

    localparam logic [2:0] StatusAccepted = 3'b010;
    localparam logic [2:0] StatusCrcErr   = 3'b101;
    localparam logic [2:0] StatusWriteErr = 3'b110;

    typedef enum logic [2:0] {
        OK,
        CRC,
        WRITE,
        FRAME,
        TIMEOUT
    } outcome_e;

    // Anything other than the two recognised tokens is reported as a write error.
    function automatic outcome_e decode_token(input logic [2:0] bits);
        outcome_e res;
        case (bits)
            StatusAccepted: res = OK;
            StatusCrcErr:   res = CRC;
            default:        res = WRITE;
        endcase
        return res;
    endfunction

    // One-hot order: {ok, crc, write, frame, timeout}.
    function automatic logic [4:0] outcome_onehot(input outcome_e o);
        logic [4:0] res;
        case (o)
            OK:      res = 5'b10000;
            CRC:     res = 5'b01000;
            WRITE:   res = 5'b00100;
            FRAME:   res = 5'b00010;
            default: res = 5'b00001;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dat_tick_counter.sv
// Saturating, clearable tick counter; hit_next_o flags that the increment
// about to happen lands exactly on cmp_val_i.
module dat_tick_counter #(
    parameter int Width = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [Width-1:0] cmp_val_i,
    output logic             hit_next_o
);

    logic [Width-1:0] count_reg;
    logic [Width-1:0] count_next;

    assign count_next = (count_reg == '1) ? count_reg : count_reg + 1'b1;
    assign hit_next_o = (count_next == cmp_val_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (clr_i) begin
            count_reg <= '0;
        end else if (inc_i) begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/dat_crc_status_rx.sv
// Receives the card's CRC status token on DAT0 after a written block, then
// tracks the busy phase and reports a single registered outcome per block.
module dat_crc_status_rx
    import dat_pkg::*;
#(
    parameter int NcrcMax          = 8,
    parameter int BusyTimeoutWidth = 24
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        sd_clk_en_p_i,
    input  logic                        dat0_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [BusyTimeoutWidth-1:0] timeout_ticks_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        status_ok_o,
    output logic                        crc_err_o,
    output logic                        write_err_o,
    output logic                        frame_err_o,
    output logic                        timeout_o,
    output logic [2:0]                  status_bits_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        STATUS,
        END_BIT,
        BUSY,
        DONE
    } state_e;

    localparam logic [BusyTimeoutWidth-1:0] NcrcCmp = BusyTimeoutWidth'(NcrcMax);

    state_e                      state_reg;
    outcome_e                    latched_reg;
    logic [1:0]                  bit_idx_reg;
    logic [2:0]                  status_bits_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic [4:0]                  outcome_reg;

    logic                        tick;
    logic                        cnt_clr;
    logic                        cnt_inc;
    logic                        cnt_hit;
    logic [BusyTimeoutWidth-1:0] cnt_cmp;

    assign tick = sd_clk_en_p_i;

    // The Ncrc window and the busy phase never overlap, so one counter serves both.
    assign cnt_clr = (state_reg == IDLE && start_i && !abort_i)
                   || (state_reg == END_BIT && tick && dat0_i);
    assign cnt_inc = tick && ((state_reg == WAIT_START && dat0_i)
                           || (state_reg == BUSY && !dat0_i));
    assign cnt_cmp = (state_reg == WAIT_START) ? NcrcCmp : timeout_ticks_i;

    dat_tick_counter #(
        .Width(BusyTimeoutWidth)
    ) u_tick_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .cmp_val_i  (cnt_cmp),
        .hit_next_o (cnt_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            latched_reg     <= OK;
            bit_idx_reg     <= '0;
            status_bits_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            outcome_reg     <= '0;
        end else begin
            done_reg    <= 1'b0;
            outcome_reg <= '0;
            if (abort_i) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_i) begin
                            state_reg       <= WAIT_START;
                            status_bits_reg <= '0;
                            busy_reg        <= 1'b1;
                        end
                    end
                    WAIT_START: begin
                        if (tick) begin
                            if (!dat0_i) begin
                                state_reg   <= STATUS;
                                bit_idx_reg <= '0;
                            end else if (cnt_hit) begin
                                state_reg   <= DONE;
                                done_reg    <= 1'b1;
                                outcome_reg <= outcome_onehot(FRAME);
                            end
                        end
                    end
                    STATUS: begin
                        if (tick) begin
                            status_bits_reg <= {status_bits_reg[1:0], dat0_i};
                            if (bit_idx_reg == 2'd2) begin
                                state_reg <= END_BIT;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 2'd1;
                            end
                        end
                    end
                    END_BIT: begin
                        if (tick) begin
                            if (!dat0_i) begin
                                state_reg   <= DONE;
                                done_reg    <= 1'b1;
                                outcome_reg <= outcome_onehot(FRAME);
                            end else begin
                                state_reg   <= BUSY;
                                latched_reg <= decode_token(status_bits_reg);
                            end
                        end
                    end
                    BUSY: begin
                        if (tick) begin
                            if (dat0_i) begin
                                state_reg   <= DONE;
                                done_reg    <= 1'b1;
                                outcome_reg <= outcome_onehot(latched_reg);
                            end else if (timeout_ticks_i != '0 && cnt_hit) begin
                                state_reg   <= DONE;
                                done_reg    <= 1'b1;
                                outcome_reg <= outcome_onehot(TIMEOUT);
                            end
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign status_ok_o   = outcome_reg[4];
    assign crc_err_o     = outcome_reg[3];
    assign write_err_o   = outcome_reg[2];
    assign frame_err_o   = outcome_reg[1];
    assign timeout_o     = outcome_reg[0];
    assign status_bits_o = status_bits_reg;

endmodule

// File: tb/tb_dat_crc_status_rx.sv
// Directed bench for dat_crc_status_rx: table of token vectors plus
// hand-written Ncrc, busy-timeout, abort and reset sequences.
module tb_dat_crc_status_rx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        sd_clk_en_p_i;
    logic        dat0_i;
    logic        start_i;
    logic        abort_i;
    logic [23:0] timeout_ticks_i;
    logic        busy_o, done_o;
    logic        status_ok_o, crc_err_o, write_err_o, frame_err_o, timeout_o;
    logic [2:0]  status_bits_o;
    logic [4:0]  outc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign outc = {status_ok_o, crc_err_o, write_err_o, frame_err_o, timeout_o};

    dat_crc_status_rx #(
        .NcrcMax(8),
        .BusyTimeoutWidth(24)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .sd_clk_en_p_i   (sd_clk_en_p_i),
        .dat0_i          (dat0_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .timeout_ticks_i (timeout_ticks_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .status_ok_o     (status_ok_o),
        .crc_err_o       (crc_err_o),
        .write_err_o     (write_err_o),
        .frame_err_o     (frame_err_o),
        .timeout_o       (timeout_o),
        .status_bits_o   (status_bits_o)
    );

    typedef struct {
        string      name;
        int         pre_high;
        logic [4:0] token;     // start, b2, b1, b0, end
        int         busy_low;
        logic [4:0] exp_out;   // {ok, crc, write, frame, timeout}
        logic [2:0] exp_bits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick(input logic d);
        @(negedge clk);
        dat0_i        = d;
        sd_clk_en_p_i = 1'b1;
        @(negedge clk);
        sd_clk_en_p_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic early;
        logic drop;
        early = 1'b0;
        drop  = 1'b0;
        pulse_start();
        check({v.name, "_busy_after_start"}, 32'(busy_o), 32'd1);
        for (int i = 0; i < v.pre_high; i++) begin
            tick(1'b1);
            early |= done_o;
            drop  |= !busy_o;
        end
        for (int i = 4; i >= 1; i--) begin
            tick(v.token[i]);
            early |= done_o;
            drop  |= !busy_o;
        end
        tick(v.token[0]);
        if (v.token[0]) begin
            early |= done_o;
            drop  |= !busy_o;
            for (int i = 0; i < v.busy_low; i++) begin
                tick(1'b0);
                early |= done_o;
                drop  |= !busy_o;
            end
            tick(1'b1);
        end
        check({v.name, "_early_done"}, 32'(early), 32'd0);
        check({v.name, "_busy_dropped"}, 32'(drop), 32'd0);
        check({v.name, "_done"}, 32'(done_o), 32'd1);
        check({v.name, "_outcome"}, 32'(outc), 32'(v.exp_out));
        check({v.name, "_bits"}, 32'(status_bits_o), 32'(v.exp_bits));
        check({v.name, "_busy_in_done"}, 32'(busy_o), 32'd1);
        @(negedge clk);
        check({v.name, "_post_done"}, 32'({done_o, busy_o, outc}), 32'd0);
        $display("vector %s: token=%b busy_low=%0d outcome=%b bits=%b",
                 v.name, v.token, v.busy_low, v.exp_out, v.exp_bits);
    endtask

    initial begin
        logic seen;
        vecs[0] = '{"ok",        2, 5'b00101, 5, 5'b10000, 3'b010};
        vecs[1] = '{"crc",       0, 5'b01011, 0, 5'b01000, 3'b101};
        vecs[2] = '{"endbit0",   0, 5'b00100, 0, 5'b00010, 3'b010};
        vecs[3] = '{"wr111",     0, 5'b01111, 0, 5'b00100, 3'b111};
        vecs[4] = '{"wr110",     1, 5'b01101, 3, 5'b00100, 3'b110};
        vecs[5] = '{"ok_zero",   0, 5'b00101, 0, 5'b10000, 3'b010};

        rst_i           = 1'b1;
        sd_clk_en_p_i   = 1'b0;
        dat0_i          = 1'b1;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        timeout_ticks_i = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy_o, done_o, outc, status_bits_o}), 32'd0);
        rst_i = 1'b0;
        $display("reset released");

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Ncrc window: 8 high ticks with no start bit
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1'b1);
            seen |= done_o;
        end
        check("ncrc_no_early_done", 32'(seen), 32'd0);
        tick(1'b1);
        check("ncrc_done", 32'(done_o), 32'd1);
        check("ncrc_outcome", 32'(outc), 32'b00010);
        check("ncrc_bits_cleared", 32'(status_bits_o), 32'd0);
        @(negedge clk);
        check("ncrc_idle", 32'({busy_o, done_o}), 32'd0);
        $display("sequence ncrc: frame error after 8 ticks");

        // Busy timeout at exactly 100 low ticks
        timeout_ticks_i = 24'd100;
        pulse_start();
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick(1'b0);
            seen |= done_o;
        end
        check("timeout_no_early_done", 32'(seen), 32'd0);
        tick(1'b0);
        check("timeout_done", 32'(done_o), 32'd1);
        check("timeout_outcome", 32'(outc), 32'b00001);
        @(negedge clk);
        check("timeout_idle", 32'(busy_o), 32'd0);
        $display("sequence timeout: 100 busy ticks");

        // Timeout disabled: 10000 low ticks, then abort during BUSY
        timeout_ticks_i = '0;
        pulse_start();
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick(1'b0);
            seen |= done_o;
        end
        check("notimeout_no_done", 32'(seen), 32'd0);
        check("notimeout_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_idle", 32'({busy_o, done_o, outc}), 32'd0);
        tick(1'b1);
        check("abort_no_late_done", 32'({busy_o, done_o}), 32'd0);
        $display("sequence abort: 10000 busy ticks then abort");
        run_vec(vecs[0]);

        // abort and start together in IDLE
        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_beats_start", 32'(busy_o), 32'd0);
        $display("sequence abort+start: stays idle");

        // Asynchronous reset mid-token
        pulse_start();
        tick(1'b0); tick(1'b1);
        #2 rst_i = 1'b1;
        #1 check("async_reset_busy", 32'({busy_o, done_o, status_bits_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        tick(1'b0);
        check("reset_no_done", 32'({busy_o, done_o}), 32'd0);
        $display("sequence reset during STATUS");
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
